// File: rtl/if_id_skid_reg_if.sv
// rtl/if_id_skid_reg_if.sv - fetch/decode handshake bundle for the IF/ID skid register
interface if_id_skid_reg_if #(
   parameter int N = 32
);
   logic         validIn;
   logic [N-1:0] pcIn;
   logic [N-1:0] instrIn;
   logic         readyOut;
   logic         validOut;
   logic [N-1:0] pcOut;
   logic [N-1:0] instrOut;
   logic         readyIn;
   logic [1:0]   occupancy;

   // Pipeline environment side: fetch drives words in, decode drives readyIn
   modport master (
      output validIn, pcIn, instrIn, readyIn,
      input  readyOut, validOut, pcOut, instrOut, occupancy
   );

   // Skid register side
   modport slave (
      input  validIn, pcIn, instrIn, readyIn,
      output readyOut, validOut, pcOut, instrOut, occupancy
   );
endinterface

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - two-entry skid-buffered IF/ID register; optional IF_ID_BUBBLE_NOP_EN NOP bubble output
module if_id_skid_reg #(
   parameter int N = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   if_id_skid_reg_if.slave  bus
);
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         ready_q;
   logic         valid_q;
   logic [N-1:0] head_pc;
   logic [N-1:0] head_instr;
   logic [N-1:0] skid_pc;
   logic [N-1:0] skid_instr;
   logic         acc;
   logic         pop;

   // Handshakes use only registered ready/valid so fetch freeze never sees decode stall combinationally
   always_comb begin
      acc       = bus.validIn & ready_q;
      pop       = valid_q & bus.readyIn;
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (acc) state_nxt = ONE;
            ONE: begin
               if (acc && !pop)      state_nxt = TWO;
               else if (!acc && pop) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // State, registered handshake outputs and head/skid data; data moves only on listed transitions
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= EMPTY;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         head_pc    <= '0;
         head_instr <= '0;
         skid_pc    <= '0;
         skid_instr <= '0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != TWO);
         valid_q <= (state_nxt != EMPTY);
         if (flush) begin
            head_pc    <= '0;
            head_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
         end else begin
            case (state)
               EMPTY: begin
                  if (acc) begin
                     head_pc    <= bus.pcIn;
                     head_instr <= bus.instrIn;
                  end
               end
               ONE: begin
                  if (acc && pop) begin
                     head_pc    <= bus.pcIn;
                     head_instr <= bus.instrIn;
                  end else if (acc) begin
                     skid_pc    <= bus.pcIn;
                     skid_instr <= bus.instrIn;
                  end
               end
               TWO: begin
                  if (pop) begin
                     head_pc    <= skid_pc;
                     head_instr <= skid_instr;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.readyOut  = ready_q;
   assign bus.validOut  = valid_q;
   assign bus.occupancy = state;

`ifdef IF_ID_BUBBLE_NOP_EN
   // Empty slots present MOV R0,R0 so decode can run without qualifying validOut
   assign bus.pcOut    = valid_q ? head_pc    : '0;
   assign bus.instrOut = valid_q ? head_instr : N'(32'hE1A00000);
`else
   assign bus.pcOut    = head_pc;
   assign bus.instrOut = head_instr;
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - scoreboard bench for if_id_skid_reg
module tb_if_id_skid_reg;
   localparam int N = 32;
`ifdef IF_ID_BUBBLE_NOP_EN
   localparam logic [31:0] IDLE_INSTR = 32'hE1A00000;
`else
   localparam logic [31:0] IDLE_INSTR = 32'h0;
`endif
   localparam logic [31:0] I_A = 32'hE3A01001;
   localparam logic [31:0] I_B = 32'hE2811002;
   localparam logic [31:0] I_C = 32'hE0812003;
   localparam logic [31:0] I_D = 32'hE5912004;
   localparam logic [31:0] I_E = 32'hE1520001;
   localparam logic [31:0] I_F = 32'h1AFFFFFB;
   localparam logic [31:0] I_G = 32'hE12FFF1E;

   logic clk;
   logic rst;
   logic flush;
   int   n_cmp;
   int   n_bad;
   logic [63:0] exp_q[$];

   if_id_skid_reg_if #(.N(N)) bus ();

   if_id_skid_reg #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endfunction

   // Monitor: every decode consume pops the oldest expected word
   always @(negedge clk) begin
      if (rst && bus.validOut && bus.readyIn) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got word %h/%h, required no word", bus.pcOut, bus.instrOut);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", bus.pcOut, e[63:32]);
            chk("sb_instr", bus.instrOut, e[31:0]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(logic v, logic [31:0] pc, logic [31:0] ins);
      bus.validIn = v;
      bus.pcIn    = pc;
      bus.instrIn = ins;
   endtask

   task automatic expect_word(logic [31:0] pc, logic [31:0] ins);
      exp_q.push_back({pc, ins});
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      flush = 1'b0;
      bus.readyIn = 1'b0;
      offer(1'b0, 32'h0, 32'h0);

      // 1: reset values
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      chk("rst_valid", 32'(bus.validOut), 32'd0);
      chk("rst_ready", 32'(bus.readyOut), 32'd1);
      chk("rst_occ", 32'(bus.occupancy), 32'd0);
      chk("rst_pc", bus.pcOut, 32'd0);
      chk("rst_instr", bus.instrOut, IDLE_INSTR);

      // 2: streaming with decode always ready
      bus.readyIn = 1'b1;
      expect_word(32'd4, I_A);
      expect_word(32'd8, I_B);
      expect_word(32'd12, I_C);
      offer(1'b1, 32'd4, I_A);
      cyc();
      chk("s2_occ_a", 32'(bus.occupancy), 32'd1);
      chk("s2_pc_a", bus.pcOut, 32'd4);
      offer(1'b1, 32'd8, I_B);
      cyc();
      chk("s2_occ_b", 32'(bus.occupancy), 32'd1);
      chk("s2_ready_b", 32'(bus.readyOut), 32'd1);
      offer(1'b1, 32'd12, I_C);
      cyc();
      chk("s2_occ_c", 32'(bus.occupancy), 32'd1);
      chk("s2_instr_c", bus.instrOut, I_C);
      offer(1'b0, 32'd0, 32'd0);
      cyc();
      chk("s2_occ_end", 32'(bus.occupancy), 32'd0);
      chk("s2_valid_end", 32'(bus.validOut), 32'd0);

      // 3: back-pressure fills the skid, third word waits for readyOut
      bus.readyIn = 1'b0;
      expect_word(32'd4, I_A);
      expect_word(32'd8, I_B);
      expect_word(32'd12, I_C);
      offer(1'b1, 32'd4, I_A);
      cyc();
      offer(1'b1, 32'd8, I_B);
      cyc();
      chk("s3_occ_two", 32'(bus.occupancy), 32'd2);
      chk("s3_ready_two", 32'(bus.readyOut), 32'd0);
      chk("s3_head_pc", bus.pcOut, 32'd4);
      offer(1'b1, 32'd12, I_C);
      cyc();
      chk("s3_occ_hold", 32'(bus.occupancy), 32'd2);
      chk("s3_head_hold", bus.instrOut, I_A);
      bus.readyIn = 1'b1;
      cyc();
      chk("s3_occ_pop", 32'(bus.occupancy), 32'd1);
      chk("s3_pc_b", bus.pcOut, 32'd8);
      chk("s3_ready_pop", 32'(bus.readyOut), 32'd1);
      cyc();
      chk("s3_pc_c", bus.pcOut, 32'd12);
      chk("s3_occ_c", 32'(bus.occupancy), 32'd1);
      offer(1'b0, 32'd0, 32'd0);
      cyc();
      chk("s3_occ_end", 32'(bus.occupancy), 32'd0);

      // 4: flush in TWO discards both entries and the offered word
      bus.readyIn = 1'b0;
      offer(1'b1, 32'd20, I_D);
      cyc();
      offer(1'b1, 32'd24, I_E);
      cyc();
      chk("s4_occ_two", 32'(bus.occupancy), 32'd2);
      flush = 1'b1;
      offer(1'b1, 32'd16, I_G);
      cyc();
      flush = 1'b0;
      offer(1'b0, 32'd0, 32'd0);
      chk("s4_occ", 32'(bus.occupancy), 32'd0);
      chk("s4_valid", 32'(bus.validOut), 32'd0);
      chk("s4_ready", 32'(bus.readyOut), 32'd1);
      chk("s4_pc", bus.pcOut, 32'd0);
      chk("s4_instr", bus.instrOut, IDLE_INSTR);
      bus.readyIn = 1'b1;
      cyc(); cyc();
      chk("s4_still_empty", 32'(bus.validOut), 32'd0);

      // 5: flush in ONE together with a consume
      expect_word(32'd28, I_F);
      offer(1'b1, 32'd28, I_F);
      cyc();
      offer(1'b0, 32'd0, 32'd0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("s5_occ", 32'(bus.occupancy), 32'd0);
      chk("s5_valid", 32'(bus.validOut), 32'd0);
      cyc();
      chk("s5_no_stale", 32'(bus.validOut), 32'd0);

      // 6: asynchronous reset between edges while in TWO
      bus.readyIn = 1'b0;
      offer(1'b1, 32'd32, I_A);
      cyc();
      offer(1'b1, 32'd36, I_B);
      cyc();
      offer(1'b0, 32'd0, 32'd0);
      chk("s6_occ_two", 32'(bus.occupancy), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("s6_occ", 32'(bus.occupancy), 32'd0);
      chk("s6_valid", 32'(bus.validOut), 32'd0);
      chk("s6_ready", 32'(bus.readyOut), 32'd1);
      chk("s6_pc", bus.pcOut, 32'd0);
      chk("s6_instr", bus.instrOut, IDLE_INSTR);
      cyc();
      rst = 1'b1;
      cyc(); cyc();

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
